// File: rtl/stream_xbar_pkg.sv
// Shared constants and helpers for the stream crossbar switch and its buffers.
package stream_xbar_pkg;

   localparam int DEF_T_DATA_WIDTH = 8;
   localparam int DEF_S_DATA_COUNT = 2;
   localparam int DEF_M_DATA_COUNT = 3;
   localparam int DEF_FIFO_DEPTH   = 4;

   // Index widths never collapse to zero, so single-stream builds still get a 1-bit field.
   function automatic int safe_clog2(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/stream_xbar_switch_fifo.sv
// Per-output beat buffer: pointer-pair FIFO with an extra wrap bit for full/empty.
module stream_fifo
   import stream_xbar_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int ADDR_W = safe_clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]  r_wr_ptr;
   logic [ADDR_W:0]  r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
   end

   // Head is forced to zero when empty so stale storage never reaches the outputs.
   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/stream_xbar_switch.sv
// Packet-atomic stream crossbar: per-output round-robin arbiter with packet lock and output FIFO.
module stream_xbar_switch
   import stream_xbar_pkg::*;
#(
   parameter  int T_DATA_WIDTH = DEF_T_DATA_WIDTH,
   parameter  int S_DATA_COUNT = DEF_S_DATA_COUNT,
   parameter  int M_DATA_COUNT = DEF_M_DATA_COUNT,
   parameter  int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   localparam int T_ID___WIDTH = safe_clog2(S_DATA_COUNT),
   localparam int T_DEST_WIDTH = safe_clog2(M_DATA_COUNT)
) (
   input  logic                                       clk_i,
   input  logic                                       rst_in,
   input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
   input  logic [S_DATA_COUNT-1:0]                    s_last_i,
   input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
   output logic [S_DATA_COUNT-1:0]                    s_ready_o,
   output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o,
   output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  m_id_o,
   output logic [M_DATA_COUNT-1:0]                    m_last_o,
   output logic [M_DATA_COUNT-1:0]                    m_valid_o,
   input  logic [M_DATA_COUNT-1:0]                    m_ready_i
);

   localparam int ENT_W = T_DATA_WIDTH + T_ID___WIDTH + 1;

   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_req;
   logic [S_DATA_COUNT-1:0]                   w_dest_bad;
   logic [M_DATA_COUNT-1:0]                   w_gnt_vld;
   logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] w_gnt_id;
   logic [M_DATA_COUNT-1:0]                   w_push;
   logic [M_DATA_COUNT-1:0]                   w_pop;
   logic [M_DATA_COUNT-1:0]                   w_full;
   logic [M_DATA_COUNT-1:0]                   w_empty;
   logic [M_DATA_COUNT-1:0][ENT_W-1:0]        w_push_data;
   logic [M_DATA_COUNT-1:0][ENT_W-1:0]        w_head;
   logic [M_DATA_COUNT-1:0]                   r_lock;
   logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] r_lock_id;
   logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] r_rr_ptr;

   function automatic logic [T_ID___WIDTH-1:0] f_next_id(input logic [T_ID___WIDTH-1:0] id);
      return (int'(id) >= S_DATA_COUNT - 1) ? '0 : id + 1'b1;
   endfunction

   always_comb begin
      w_req      = '0;
      w_dest_bad = '0;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         w_dest_bad[i] = ({1'b0, s_dest_i[i]} >= (T_DEST_WIDTH + 1)'(M_DATA_COUNT));
         for (int j = 0; j < M_DATA_COUNT; j++)
            w_req[j][i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j));
      end
   end

   // A locked output keeps granting its packet owner even through valid gaps.
   always_comb begin
      w_gnt_vld = '0;
      w_gnt_id  = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         if (r_lock[j]) begin
            w_gnt_vld[j] = 1'b1;
            w_gnt_id[j]  = r_lock_id[j];
         end else begin
            for (int k = 0; k < S_DATA_COUNT; k++) begin
               if (!w_gnt_vld[j] &&
                   w_req[j][T_ID___WIDTH'((int'(r_rr_ptr[j]) + k) % S_DATA_COUNT)]) begin
                  w_gnt_vld[j] = 1'b1;
                  w_gnt_id[j]  = T_ID___WIDTH'((int'(r_rr_ptr[j]) + k) % S_DATA_COUNT);
               end
            end
         end
      end
   end

   // Ready depends only on grant and FIFO fill state, never on downstream ready.
   always_comb begin
      s_ready_o   = '0;
      w_push      = '0;
      w_push_data = '0;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         if (w_dest_bad[i]) begin
            s_ready_o[i] = rst_in;
         end else begin
            for (int j = 0; j < M_DATA_COUNT; j++)
               if ((s_dest_i[i] == T_DEST_WIDTH'(j)) && w_gnt_vld[j] && !w_full[j] &&
                   (w_gnt_id[j] == T_ID___WIDTH'(i)))
                  s_ready_o[i] = rst_in;
         end
      end
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         w_push[j]      = rst_in && w_gnt_vld[j] && !w_full[j] && w_req[j][w_gnt_id[j]];
         w_push_data[j] = {s_data_i[w_gnt_id[j]], w_gnt_id[j], s_last_i[w_gnt_id[j]]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_lock    <= '0;
         r_lock_id <= '0;
         r_rr_ptr  <= '0;
      end else begin
         for (int j = 0; j < M_DATA_COUNT; j++) begin
            if (w_push[j]) begin
               if (w_push_data[j][0]) begin
                  r_lock[j]   <= 1'b0;
                  r_rr_ptr[j] <= f_next_id(w_gnt_id[j]);
               end else begin
                  r_lock[j]    <= 1'b1;
                  r_lock_id[j] <= w_gnt_id[j];
               end
            end
         end
      end
   end

   for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
      stream_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_in  (rst_in),
         .i_push  (w_push[j]),
         .i_data  (w_push_data[j]),
         .i_pop   (w_pop[j]),
         .o_data  (w_head[j]),
         .o_full  (w_full[j]),
         .o_empty (w_empty[j])
      );
      assign m_valid_o[j] = !w_empty[j];
      assign w_pop[j]     = !w_empty[j] && m_ready_i[j];
      assign {m_data_o[j], m_id_o[j], m_last_o[j]} = w_head[j];
   end

endmodule

// File: tb/tb_stream_xbar_switch.sv
// Randomised and directed checks of stream_xbar_switch against a queue-based packet model.
module tb_stream_xbar_switch;

   localparam int W = 8;
   localparam int S = 2;
   localparam int M = 3;
   localparam int D = 4;

   logic                clk_i = 1'b0;
   logic                rst_in = 1'b0;
   logic [S-1:0][W-1:0] s_data_i;
   logic [S-1:0][1:0]   s_dest_i;
   logic [S-1:0]        s_last_i;
   logic [S-1:0]        s_valid_i;
   logic [S-1:0]        s_ready_o;
   logic [M-1:0][W-1:0] m_data_o;
   logic [M-1:0][0:0]   m_id_o;
   logic [M-1:0]        m_last_o;
   logic [M-1:0]        m_valid_o;
   logic [M-1:0]        m_ready_i;

   stream_xbar_switch #(
      .T_DATA_WIDTH (W),
      .S_DATA_COUNT (S),
      .M_DATA_COUNT (M),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk_i     (clk_i),
      .rst_in    (rst_in),
      .s_data_i  (s_data_i),
      .s_dest_i  (s_dest_i),
      .s_last_i  (s_last_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .m_data_o  (m_data_o),
      .m_id_o    (m_id_o),
      .m_last_o  (m_last_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {logic [1:0] dest; logic [7:0] data; logic last;} beat_t;
   typedef struct {logic [7:0] data; int id; logic last;} ent_t;

   beat_t dq[S][$];
   ent_t  mq[M][$];
   ent_t  lg[M][$];
   bit    mlock[M];
   int    mlock_id[M];
   int    mrr[M];
   int    acc_cnt[S];
   bit    gaps;
   bit    rand_ready;
   logic [S-1:0] exp_ready;
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < M; j++) begin
         mq[j].delete();
         mlock[j]    = 1'b0;
         mlock_id[j] = 0;
         mrr[j]      = 0;
      end
      for (int i = 0; i < S; i++) dq[i].delete();
   endtask

   // One clock: drive at posedge+1, check at negedge, advance the model after posedge.
   task automatic step();
      bit gv[M];
      int gid[M];
      for (int i = 0; i < S; i++) begin
         if (dq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            s_valid_i[i] = 1'b1;
            s_dest_i[i]  = dq[i][0].dest;
            s_data_i[i]  = dq[i][0].data;
            s_last_i[i]  = dq[i][0].last;
         end else begin
            s_valid_i[i] = 1'b0;
            s_dest_i[i]  = 2'($urandom);
            s_data_i[i]  = 8'($urandom);
            s_last_i[i]  = 1'($urandom);
         end
      end
      if (rand_ready) m_ready_i = 3'($urandom);
      @(negedge clk_i);
      for (int j = 0; j < M; j++) begin
         gv[j]  = mlock[j];
         gid[j] = mlock_id[j];
         for (int k = 0; k < S; k++) begin
            int idx;
            idx = (mrr[j] + k) % S;
            if (!gv[j] && s_valid_i[idx] && int'(s_dest_i[idx]) == j) begin
               gv[j]  = 1'b1;
               gid[j] = idx;
            end
         end
      end
      for (int i = 0; i < S; i++) begin
         int d;
         d = int'(s_dest_i[i]);
         if (d >= M) exp_ready[i] = 1'b1;
         else        exp_ready[i] = gv[d] && gid[d] == i && mq[d].size() < D;
         check($sformatf("s_ready[%0d]", i), s_ready_o[i], exp_ready[i]);
      end
      for (int j = 0; j < M; j++) begin
         check($sformatf("m_valid[%0d]", j), m_valid_o[j], mq[j].size() > 0);
         if (mq[j].size() > 0) begin
            check($sformatf("m_data[%0d]", j), m_data_o[j], mq[j][0].data);
            check($sformatf("m_id[%0d]", j), m_id_o[j], mq[j][0].id);
            check($sformatf("m_last[%0d]", j), m_last_o[j], mq[j][0].last);
         end
         if (m_valid_o[j] && m_ready_i[j])
            lg[j].push_back('{data: m_data_o[j], id: int'(m_id_o[j]), last: m_last_o[j]});
      end
      @(posedge clk_i);
      #1;
      for (int j = 0; j < M; j++)
         if (mq[j].size() > 0 && m_ready_i[j]) void'(mq[j].pop_front());
      for (int i = 0; i < S; i++) begin
         if (s_valid_i[i] && exp_ready[i]) begin
            int d;
            d = int'(s_dest_i[i]);
            acc_cnt[i]++;
            if (dq[i].size() > 0) void'(dq[i].pop_front());
            if (d < M) begin
               mq[d].push_back('{data: s_data_i[i], id: i, last: s_last_i[i]});
               if (s_last_i[i]) begin
                  mlock[d] = 1'b0;
                  mrr[d]   = (i + 1) % S;
               end else begin
                  mlock[d]    = 1'b1;
                  mlock_id[d] = i;
               end
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"}, s_ready_o, 0);
      check({tag, "_m_valid"}, m_valid_o, 0);
      check({tag, "_m_data"}, m_data_o, 0);
      check({tag, "_m_id"}, m_id_o, 0);
      check({tag, "_m_last"}, m_last_o, 0);
   endtask

   initial begin
      s_valid_i  = '1;
      s_dest_i   = {2'd3, 2'd3};
      s_data_i   = '0;
      s_last_i   = '0;
      m_ready_i  = '0;
      gaps       = 1'b0;
      rand_ready = 1'b0;
      exp_ready  = '0;
      for (int i = 0; i < S; i++) acc_cnt[i] = 0;
      model_reset();
      #2;
      check_all_zero("reset");
      s_valid_i = '0;
      @(posedge clk_i);
      #1;
      rst_in    = 1'b1;
      m_ready_i = '1;

      // Single-beat packet to output 2.
      dq[0].push_back('{dest: 2'd2, data: 8'hA5, last: 1'b1});
      step();
      check("a5_accepted", acc_cnt[0], 1);
      check("a5_valid", m_valid_o[2], 1);
      check("a5_data", m_data_o[2], 8'hA5);
      check("a5_id", m_id_o[2], 0);
      check("a5_last", m_last_o[2], 1);
      step();

      // Competing 3-beat packets to output 1 must not interleave.
      for (int k = 0; k < 3; k++) begin
         dq[0].push_back('{dest: 2'd1, data: 8'(8'h20 + k), last: (k == 2)});
         dq[1].push_back('{dest: 2'd1, data: 8'(8'h30 + k), last: (k == 2)});
      end
      lg[1].delete();
      repeat (9) step();
      check("order_count", lg[1].size(), 6);
      for (int k = 0; k < lg[1].size(); k++)
         check($sformatf("order_id[%0d]", k), lg[1][k].id, (k < 3) ? 0 : 1);

      // Backpressure: output 0 stalled, FIFO fills at four beats.
      m_ready_i = 3'b110;
      for (int k = 0; k < 6; k++)
         dq[1].push_back('{dest: 2'd0, data: 8'(8'h40 + k), last: (k == 5)});
      acc_cnt[1] = 0;
      repeat (8) step();
      check("full_accepted", acc_cnt[1], 4);
      check("full_ready", s_ready_o[1], 0);
      m_ready_i = 3'b111;
      lg[0].delete();
      repeat (10) step();
      check("full_delivered", lg[0].size(), 6);
      for (int k = 0; k < lg[0].size(); k++)
         check($sformatf("full_data[%0d]", k), lg[0][k].data, 8'h40 + k);

      // Out-of-range destination is swallowed.
      dq[0].push_back('{dest: 2'd3, data: 8'h5A, last: 1'b1});
      acc_cnt[0] = 0;
      step();
      check("bad_dest_accepted", acc_cnt[0], 1);
      check("bad_dest_no_valid", m_valid_o, 0);

      // Reset in the middle of a packet.
      m_ready_i = '0;
      for (int k = 0; k < 4; k++)
         dq[0].push_back('{dest: 2'd1, data: 8'(8'h60 + k), last: (k == 3)});
      repeat (2) step();
      check("pre_reset_valid", m_valid_o[1], 1);
      rst_in = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      s_valid_i = '0;
      @(posedge clk_i);
      #1;
      rst_in    = 1'b1;
      m_ready_i = '1;
      dq[1].push_back('{dest: 2'd1, data: 8'h70, last: 1'b0});
      dq[1].push_back('{dest: 2'd1, data: 8'h71, last: 1'b1});
      lg[1].delete();
      repeat (5) step();
      check("post_reset_count", lg[1].size(), 2);
      for (int k = 0; k < lg[1].size(); k++) begin
         check($sformatf("post_reset_id[%0d]", k), lg[1][k].id, 1);
         check($sformatf("post_reset_data[%0d]", k), lg[1][k].data, 8'h70 + k);
      end

      // Random packets with valid gaps and random downstream ready.
      gaps       = 1'b1;
      rand_ready = 1'b1;
      repeat (3000) begin
         for (int i = 0; i < S; i++) begin
            if (dq[i].size() == 0) begin
               int len;
               int d;
               len = $urandom_range(1, 4);
               d   = $urandom_range(0, 3);
               for (int k = 0; k < len; k++)
                  dq[i].push_back('{dest: 2'(d), data: 8'($urandom), last: (k == len - 1)});
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_xbar_switch.md
STREAM_XBAR_SWITCH -- requirements
Module: stream_xbar_switch

Interface
REQ-001 SHALL take parameter T_DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL take parameter S_DATA_COUNT, default 2, number of input streams (>=1).
REQ-003 SHALL take parameter M_DATA_COUNT, default 3, number of output streams (>=1).
REQ-004 SHALL take parameter FIFO_DEPTH, default 4, per-output buffer depth (power of 2, >=2).
REQ-005 SHALL derive T_ID___WIDTH = max(1, clog2(S_DATA_COUNT)) and T_DEST_WIDTH = max(1, clog2(M_DATA_COUNT)).
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk_i  in  1  clock, all state on rising edge.
REQ-008 rst_in  in  1  asynchronous active-low reset.
REQ-009 s_data_i  in  [S_DATA_COUNT] x T_DATA_WIDTH  input payloads.
REQ-010 s_dest_i  in  [S_DATA_COUNT] x T_DEST_WIDTH  destination output index per input.
REQ-011 s_last_i  in  S_DATA_COUNT  end-of-packet flag per input.
REQ-012 s_valid_i  in  S_DATA_COUNT  input beat valid.
REQ-013 s_ready_o  out  S_DATA_COUNT  input beat accepted when valid&&ready.
REQ-014 m_data_o  out  [M_DATA_COUNT] x T_DATA_WIDTH  output payloads.
REQ-015 m_id_o  out  [M_DATA_COUNT] x T_ID___WIDTH  index of source input of the beat.
REQ-016 m_last_o  out  M_DATA_COUNT  end-of-packet flag per output.
REQ-017 m_valid_o  out  M_DATA_COUNT  output beat valid.
REQ-018 m_ready_i  in  M_DATA_COUNT  downstream ready per output.

Function
REQ-019 Input i SHALL request output j when s_valid_i[i] && s_dest_i[i]==j.
REQ-020 Each output SHALL own a round-robin arbiter; when unlocked it grants, in the same cycle, the first requester at or after rr_ptr[j], wrapping S_DATA_COUNT-1 -> 0.
REQ-021 s_ready_o[i] SHALL be 1 only when i is granted by output s_dest_i[i] and that output's FIFO is not full; it SHALL have no combinational path from m_ready_i.
REQ-022 Accepting a beat with last=0 SHALL lock output j to input i; accepting a beat with last=1 SHALL clear the lock and set rr_ptr[j] to (i+1) mod S_DATA_COUNT.
REQ-023 While locked, output j SHALL grant only the locked input, even if it deasserts s_valid_i or other inputs request j.
REQ-024 Single-beat packets (last=1 on first beat) SHALL not lock and SHALL advance rr_ptr[j].
REQ-025 A beat whose s_dest_i >= M_DATA_COUNT SHALL be accepted (s_ready_o=1) and discarded, affecting no output state.
REQ-026 An accepted beat SHALL be pushed into FIFO j as {data, id=i, last}; m_valid_o[j] SHALL equal FIFO-not-empty; the head drives m_data_o, m_id_o, m_last_o.
REQ-027 A pop SHALL occur on m_valid_o[j] && m_ready_i[j]; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-028 When full, a pop SHALL NOT enable a push in the same cycle; push resumes the next cycle.
REQ-029 Latency: beat accepted in cycle N SHALL appear on m_valid_o in cycle N+1 at earliest.
REQ-030 With m_ready_i held 1 and one locked input streaming, throughput SHALL be one beat per cycle per output.
REQ-031 Outputs SHALL hold data, id and last stable while m_valid_o=1 and m_ready_i=0.

Reset
REQ-032 While rst_in=0: m_valid_o=0, s_ready_o=0, m_last_o=0, m_id_o=0, m_data_o=0, FIFOs empty, locks cleared, rr_ptr=0.
REQ-033 Reset mid-packet SHALL discard buffered beats and locks; the truncated packet is never completed downstream.

Structure
REQ-034 Package stream_xbar_pkg SHALL hold the safe-clog2 helper function and default parameter constants.
REQ-035 Sub-module stream_fifo (parametrised width/depth, full/empty, async active-low reset) SHALL be instantiated once per output.

Verification
REQ-036 S=2,M=3: input0 sends 1-beat packet 0xA5 to dest 2 -> m_valid_o[2] one cycle later, data 0xA5, id 0, last 1.
REQ-037 Inputs 0 and 1 both send 3-beat packets to dest 1, same cycle -> output 1 shows 3 beats id 0, then 3 beats id 1, never interleaved.
REQ-038 m_ready_i[0]=0, input1 streams 6 beats to dest 0 with FIFO_DEPTH=4 -> 4 accepted, s_ready_o[1]=0 until m_ready_i[0]=1, then all 6 delivered in order.
REQ-039 s_dest_i=3 with M=3, valid 1 -> s_ready_o=1, no m_valid_o on any output.
REQ-040 Assert rst_in=0 after beat 2 of 4-beat packet -> all outputs 0 immediately, FIFOs empty, next packet from input1 granted normally after release.
